// File: rtl/cfg_seq_pkg.sv
// Shared types and entry field helpers for the I2C configuration sequencer.
package cfg_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_WRITE,
    ST_READ,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } cfg_state_e;

  // Delay counts are scaled by a 16-bit unit, so the counter grows by this much
  localparam int unsigned DELAY_UNIT_W = 16;

  // Wide all-ones constant; sliced to the address width for the default delay marker
  localparam logic [15:0] DELAY_ADDR_ALL1 = 16'hFFFF;

  // LUT entry layout is {addr, data}, data in the low bits
  localparam int unsigned DATA_LSB = 0;

  function automatic int unsigned addr_msb(input int unsigned aw, input int unsigned dw);
    return aw + dw - 1;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned data_msb(input int unsigned dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/cfg_wait_counter.sv
// Loadable down-counter with a zero flag; used for the power-up wait and delay entries.
module cfg_wait_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_cnt;

  // Load has priority; decrement saturates at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks a {reg addr, reg data} config LUT and issues one I2C write per entry,
// with power-up wait, delay entries, optional read-back verify and bounded retries.
module i2c_cfg_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int unsigned               REG_ADDR_W = 8,
  parameter int unsigned               REG_DATA_W = 16,
  parameter int unsigned               IDX_W      = 8,
  parameter logic [19:0]               INIT_WAIT  = 20'd1_000_000,
  parameter logic [REG_ADDR_W-1:0]     DELAY_ADDR = DELAY_ADDR_ALL1[REG_ADDR_W-1:0],
  parameter logic [15:0]               DELAY_UNIT = 16'd1000,
  parameter bit                        VERIFY_EN  = 1'b1,
  parameter int unsigned               MAX_RETRY  = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_restart,
  output logic [IDX_W-1:0]               lut_index,
  input  logic [REG_ADDR_W+REG_DATA_W-1:0] lut_data,
  input  logic [IDX_W-1:0]               lut_size,
  output logic                           i2c_wr_req,
  output logic                           i2c_rd_req,
  output logic [REG_ADDR_W-1:0]          i2c_addr,
  output logic [REG_DATA_W-1:0]          i2c_wdata,
  input  logic [REG_DATA_W-1:0]          i2c_rdata,
  input  logic                           i2c_done,
  input  logic                           i2c_nack,
  output logic                           cfg_busy,
  output logic                           cfg_done,
  output logic                           cfg_error,
  output logic [IDX_W-1:0]               err_index
);

  localparam int unsigned CNT_W    = REG_DATA_W + DELAY_UNIT_W;
  localparam int unsigned RETRY_W  = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam int unsigned ADDR_MSB = addr_msb(REG_ADDR_W, REG_DATA_W);
  localparam int unsigned ADDR_LSB = addr_lsb(REG_DATA_W);
  localparam int unsigned DATA_MSB = data_msb(REG_DATA_W);
  // INIT spends one cycle loading and then counts down to zero, hence the -2
  localparam logic [CNT_W-1:0]   INIT_LOAD  = (INIT_WAIT >= 20'd2) ? CNT_W'(INIT_WAIT - 20'd2) : '0;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  cfg_state_e            r_state;
  logic [IDX_W-1:0]      r_index;
  logic [IDX_W-1:0]      r_err_index;
  logic [REG_ADDR_W-1:0] r_addr;
  logic [REG_DATA_W-1:0] r_wdata;
  logic [RETRY_W-1:0]    r_retry;
  logic                  r_wr_req;
  logic                  r_rd_req;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic                  r_init_loaded;

  logic [REG_ADDR_W-1:0] w_lut_addr;
  logic [REG_DATA_W-1:0] w_lut_data;
  logic                  w_is_delay;
  logic [CNT_W-1:0]      w_delay_prod;
  logic [IDX_W-1:0]      w_index_nxt;
  logic                  w_cnt_load;
  logic                  w_cnt_dec;
  logic [CNT_W-1:0]      w_cnt_val;
  logic                  w_cnt_zero;
  logic                  w_retry_last;

  assign w_lut_addr   = lut_data[ADDR_MSB:ADDR_LSB];
  assign w_lut_data   = lut_data[DATA_MSB:DATA_LSB];
  assign w_is_delay   = (w_lut_addr == DELAY_ADDR);
  assign w_delay_prod = CNT_W'(w_lut_data) * CNT_W'(DELAY_UNIT);
  assign w_index_nxt  = r_index + IDX_W'(1);
  assign w_retry_last = (r_retry == RETRY_LAST);

  // Counter control: INIT loads once then counts; FETCH of a delay entry loads the delay
  assign w_cnt_load = ((r_state == ST_INIT) && !r_init_loaded) ||
                      ((r_state == ST_FETCH) && w_is_delay);
  assign w_cnt_val  = (r_state == ST_FETCH) ? w_delay_prod : INIT_LOAD;
  assign w_cnt_dec  = ((r_state == ST_INIT) && r_init_loaded) || (r_state == ST_DELAY);

  cfg_wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero_c   (w_cnt_zero)
  );

  // Sequencer FSM with registered outputs; restart overrides everything, including i2c_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_INIT;
      r_index       <= '0;
      r_err_index   <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_retry       <= '0;
      r_wr_req      <= 1'b0;
      r_rd_req      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_init_loaded <= 1'b0;
    end else if (cfg_restart) begin
      r_state       <= ST_INIT;
      r_index       <= '0;
      r_wr_req      <= 1'b0;
      r_rd_req      <= 1'b0;
      r_busy        <= 1'b1;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_init_loaded <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_busy <= 1'b1;
          if (!r_init_loaded) begin
            r_init_loaded <= 1'b1;
          end else if (w_cnt_zero) begin
            r_index <= '0;
            if (lut_size == '0) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          r_addr  <= w_lut_addr;
          r_wdata <= w_lut_data;
          if (w_is_delay) begin
            r_state <= ST_DELAY;
          end else begin
            r_retry  <= '0;
            r_wr_req <= 1'b1;
            r_state  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (r_wr_req && i2c_done) begin
            r_wr_req <= 1'b0;
            if (i2c_nack) begin
              if (w_retry_last) begin
                r_state     <= ST_ERROR;
                r_busy      <= 1'b0;
                r_error     <= 1'b1;
                r_err_index <= r_index;
              end else begin
                // stay in WRITE; request re-asserts after one idle cycle
                r_retry <= r_retry + RETRY_W'(1);
              end
            end else if (VERIFY_EN) begin
              r_rd_req <= 1'b1;
              r_state  <= ST_READ;
            end else begin
              r_state <= ST_NEXT;
            end
          end else if (!r_wr_req) begin
            r_wr_req <= 1'b1;
          end
        end
        ST_READ: begin
          if (i2c_done) begin
            r_rd_req <= 1'b0;
            if (!i2c_nack && (i2c_rdata == r_wdata)) begin
              r_state <= ST_NEXT;
            end else if (w_retry_last) begin
              r_state     <= ST_ERROR;
              r_busy      <= 1'b0;
              r_error     <= 1'b1;
              r_err_index <= r_index;
            end else begin
              r_retry  <= r_retry + RETRY_W'(1);
              r_wr_req <= 1'b1;
              r_state  <= ST_WRITE;
            end
          end
        end
        ST_DELAY: begin
          if (w_cnt_zero) begin
            r_state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          r_index <= w_index_nxt;
          if (w_index_nxt == lut_size) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_FETCH;
          end
        end
        ST_DONE, ST_ERROR: begin
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign lut_index  = r_index;
  assign err_index  = r_err_index;
  assign i2c_addr   = r_addr;
  assign i2c_wdata  = r_wdata;
  assign i2c_wr_req = r_wr_req;
  assign i2c_rd_req = r_rd_req;
  assign cfg_busy   = r_busy;
  assign cfg_done   = r_done;
  assign cfg_error  = r_error;

endmodule
